// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline sequencing controller for the five-stage core.
//
// Turns the execute-stage redirect, the ID/EX load-use condition and the
// instruction/data memory stall lines into pipeline-register write enables,
// bubble strobes and the PC source select.
//
// Behaviour summary:
//   * A redirect that resolves while a fetch is stalled is latched into
//     redirect_pc.
//   * The latched redirect is replayed once the fetch completes.
//   * The core freezes in HALTED once a halt retires.
//   * Saturating stall and flush counters are maintained.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   ex_flush/ex_next_pc  redirect request and target from EX
//   IDEX_MemRead/IDEX_DstRegNum, IFID_Instr, IFID_ValidRs/Rt  load-use inputs
//   imem_stall, dmem_stall                                   memory stall lines
//   halt_wb              halt instruction retiring in WB
//   PC_WE, PC_Sel        PC enable and source (00 pc+2, 01 ex_next_pc, 10 redirect_pc)
//   redirect_pc          latched pending redirect target
//   IFID_WE, IDEX_WE, EXMEM_WE               pipeline register enables
//   IFID_Flush, IDEX_Flush, MEMWB_Flush      bubble strobes
//   halted               core is halted
//   stall_cnt, flush_cnt saturating performance counters
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_flush,
    input  logic [15:0]      ex_next_pc,
    input  logic             IDEX_MemRead,
    input  logic [2:0]       IDEX_DstRegNum,
    input  logic [15:0]      IFID_Instr,
    input  logic             IFID_ValidRs,
    input  logic             IFID_ValidRt,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    input  logic             halt_wb,
    output logic             PC_WE,
    output logic [1:0]       PC_Sel,
    output logic [15:0]      redirect_pc,
    output logic             IFID_WE,
    output logic             IDEX_WE,
    output logic             EXMEM_WE,
    output logic             IFID_Flush,
    output logic             IDEX_Flush,
    output logic             MEMWB_Flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [0:0] S_RUN    = 1'b0;
    localparam logic [0:0] S_HALTED = 1'b1;

    logic [0:0]  state;
    logic        pend;
    logic        pend_nxt;
    logic [15:0] rpc_nxt;
    logic        flush_inc;
    logic        load_use;

    assign load_use = IDEX_MemRead &&
                      ((IFID_ValidRs && (IFID_Instr[10:8] == IDEX_DstRegNum)) ||
                       (IFID_ValidRt && (IFID_Instr[7:5]  == IDEX_DstRegNum)));

    always_comb begin
        PC_WE       = 1'b1;
        PC_Sel      = 2'b00;
        IFID_WE     = 1'b1;
        IDEX_WE     = 1'b1;
        EXMEM_WE    = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Flush  = 1'b0;
        MEMWB_Flush = 1'b0;
        halted      = 1'b0;
        pend_nxt    = pend;
        rpc_nxt     = redirect_pc;
        flush_inc   = 1'b0;

        if (rst) begin
            PC_WE       = 1'b0;
            IFID_WE     = 1'b0;
            IDEX_WE     = 1'b0;
            EXMEM_WE    = 1'b0;
            IFID_Flush  = 1'b1;
            IDEX_Flush  = 1'b1;
            MEMWB_Flush = 1'b1;
        end else if (state == S_HALTED) begin
            PC_WE    = 1'b0;
            IFID_WE  = 1'b0;
            IDEX_WE  = 1'b0;
            EXMEM_WE = 1'b0;
            halted   = 1'b1;
        end else if (dmem_stall) begin
            // Whole pipe frozen; EX keeps its redirect and re-asserts it later.
            PC_WE       = 1'b0;
            IFID_WE     = 1'b0;
            IDEX_WE     = 1'b0;
            EXMEM_WE    = 1'b0;
            MEMWB_Flush = 1'b1;
        end else if (ex_flush && imem_stall) begin
            // Fetch can't take the new PC yet: park the target.
            PC_WE      = 1'b0;
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
            rpc_nxt    = ex_next_pc;
            pend_nxt   = 1'b1;
            flush_inc  = 1'b1;
        end else if (ex_flush) begin
            // A newer redirect supersedes any parked one.
            PC_Sel     = 2'b01;
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
            pend_nxt   = 1'b0;
            flush_inc  = 1'b1;
        end else if (imem_stall) begin
            PC_WE      = 1'b0;
            IFID_Flush = 1'b1;
        end else if (pend) begin
            // The fetch that just completed was wrong-path; drop it.
            PC_Sel     = 2'b10;
            IFID_Flush = 1'b1;
            pend_nxt   = 1'b0;
        end else if (load_use) begin
            PC_WE      = 1'b0;
            IFID_WE    = 1'b0;
            IDEX_Flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_RUN;
            pend        <= 1'b0;
            redirect_pc <= 16'h0000;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else if (state == S_RUN) begin
            pend        <= pend_nxt;
            redirect_pc <= rpc_nxt;
            if (!PC_WE && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + CNT_W'(1);
            if (halt_wb && !dmem_stall)
                state <= S_HALTED;
        end
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage core. It watches the execute-stage redirect (`flush`/`next_pc`), the ID/EX load-use condition and the instruction/data memory stall lines. From these it produces every pipeline-register write-enable, bubble/flush strobe and PC source select. It also latches a branch redirect that resolves while a fetch is stalled, holds the core in a HALTED state once `halt` retires, and keeps saturating stall and flush performance counters.

## Interface
Parameters:
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ex_flush`  in  1  redirect request from the execute stage (taken branch, jump, halt, rti).
- `ex_next_pc`  in  16  redirect target from the execute stage.
- `IDEX_MemRead`  in  1  the instruction in EX is a load.
- `IDEX_DstRegNum`  in  3  destination register of the instruction in EX.
- `IFID_Instr`  in  16  instruction in ID; rs = [10:8], rt = [7:5].
- `IFID_ValidRs`, `IFID_ValidRt`  in  1 each  the ID instruction reads rs / rt.
- `imem_stall`  in  1  instruction fetch not complete.
- `dmem_stall`  in  1  data access in MEM not complete.
- `halt_wb`  in  1  a halt instruction is in WB.
- `PC_WE`  out  1  PC write enable.
- `PC_Sel`  out  2  00 = pc+2, 01 = ex_next_pc, 10 = redirect_pc.
- `redirect_pc`  out  16  latched pending redirect target.
- `IFID_WE`, `IDEX_WE`, `EXMEM_WE`  out  1 each  pipeline register enables.
- `IFID_Flush`, `IDEX_Flush`, `MEMWB_Flush`  out  1 each  load a NOP bubble.
- `halted`  out  1  the core is halted.
- `stall_cnt`  out  CNT_W  cycles with `PC_WE` = 0 while in RUN.
- `flush_cnt`  out  CNT_W  accepted redirects.

## Operation
State: `RUN`, `HALTED`, plus `pend` (1 bit) and `redirect_pc` (16 bit).

Outputs in `RUN` use the first matching rule below. Any enable not listed is 1; any flush not listed is 0.
1. `dmem_stall`: `PC_WE`, `IFID_WE`, `IDEX_WE` and `EXMEM_WE` are 0, and `MEMWB_Flush` = 1. `ex_flush` is ignored; the EX instruction is held and re-asserts its redirect. `pend` is unchanged.
2. `ex_flush` && `imem_stall`: `PC_WE` = 0, `IFID_Flush` = 1, `IDEX_Flush` = 1. At the clock edge, `redirect_pc` <= `ex_next_pc` and `pend` <= 1. `flush_cnt` increments.
3. `ex_flush` && !`imem_stall`: `PC_Sel` = 01, `IFID_Flush` = 1, `IDEX_Flush` = 1, `flush_cnt` increments. If `pend` is set, it clears, because the newer redirect wins.
4. `imem_stall`: `PC_WE` = 0, `IFID_Flush` = 1.
5. `pend` && !`imem_stall`: `PC_Sel` = 10, `IFID_Flush` = 1 (the wrong-path fetch is discarded), and `pend` clears at the edge.
6. Load-use: `IDEX_MemRead` && ((`IFID_ValidRs` && rs == `IDEX_DstRegNum`) || (`IFID_ValidRt` && rt == `IDEX_DstRegNum`)). `PC_WE` = 0, `IFID_WE` = 0, `IDEX_Flush` = 1. Exactly one bubble is inserted.
7. Otherwise: `PC_Sel` = 00, all enables are 1.

Halt:
- `halt_wb` && !`dmem_stall` in `RUN` moves the controller to `HALTED` at the next edge.
- In `HALTED`: all WE outputs are 0, all flushes are 0, `halted` = 1, counters are frozen, and all inputs are ignored.
- Only `rst` leaves `HALTED`.

Counters saturate at all-ones and never wrap. `stall_cnt` increments in `RUN` whenever `PC_WE` = 0.

## Timing
- All outputs are combinational from the current state and inputs, with no added latency.
- `pend`, `redirect_pc`, the state and the counters update on the rising edge of `clk`.
- While `rst` = 1: `PC_WE` = 0, all other WE = 0, `IFID_Flush` = `IDEX_Flush` = `MEMWB_Flush` = 1, `PC_Sel` = 00, `halted` = 0.
- At the first edge with `rst` = 1: state <= `RUN`, `pend` <= 0, `redirect_pc` <= 0, `stall_cnt` <= 0, `flush_cnt` <= 0.
- Reset asserted mid-stall or while `pend` is set discards the pending redirect.
- A redirect latched under `imem_stall` takes effect in the first cycle `imem_stall` is 0, unless `dmem_stall` is asserted in that cycle. Rule 1 outranks rule 5, so the redirect waits.
- `ex_flush` and load-use in the same cycle: the flush wins and no load-use stall occurs.
- A `dmem_stall` lasting N cycles freezes the pipeline for exactly N cycles and inserts N WB bubbles.

## Test plan
- Load-use: `IDEX_MemRead` = 1, `IDEX_DstRegNum` = 3, `IFID_Instr[10:8]` = 3, `IFID_ValidRs` = 1 → exactly one cycle with `PC_WE` = 0, `IFID_WE` = 0, `IDEX_Flush` = 1. The next cycle is normal, and `stall_cnt` = 1.
- Branch with no stall: `ex_flush` = 1, `ex_next_pc` = 0x0040 → `PC_Sel` = 01, `IFID_Flush` = `IDEX_Flush` = 1, `flush_cnt` = 1.
- Redirect during fetch stall: `ex_flush` = 1, target 0x1234, with `imem_stall` held for 3 cycles → `redirect_pc` = 0x1234. When `imem_stall` falls: `PC_Sel` = 10, `IFID_Flush` = 1, and `pend` is 0 one cycle later.
- Data stall over a pending redirect: `pend` set and `dmem_stall` held for 2 cycles → all WE = 0 and `MEMWB_Flush` = 1 for both cycles, then `PC_Sel` = 10.
- Halt: `halt_wb` = 1 → `halted` = 1 from the next cycle. All WE stay 0 under random input activity, and `rst` returns the controller to `RUN` with counters at 0.
- Saturation: set `CNT_W` = 4 and hold `imem_stall` for 20 cycles → `stall_cnt` = 15 and holds there.
